integer_file_mp: RTL and testbench

//  Parametrised multi-port integer register file for multi-issue Steel Core variants.
//  - Read ports: NUM_RD. Write ports: NUM_WR.
//  - Same-cycle write-to-read bypass. Optional hardwired-zero x0. Optional registered reads.
//  - Reset runs a sequential clear walk, so the array can map to RAM without per-entry reset.
//  - Sits between decode (reads) and writeback (writes).

---
 rtl/integer_file_mp_pkg.sv | 16 +
 rtl/integer_file_mp_clear_seq.sv | 56 +++++
 rtl/integer_file_mp.sv | 96 +++++++++
 tb/tb_integer_file_mp.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/integer_file_mp_pkg.sv
// Shared types and constants for the multi-port integer register file.
// Holds clear-walk state encoding, read-mode constants and port-count limits.
package integer_file_mp_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int RF_READ_COMB = 0;
    localparam int RF_READ_REG  = 1;

    localparam int RF_MAX_RD = 4;
    localparam int RF_MAX_WR = 2;

endpackage

// File: rtl/integer_file_mp_clear_seq.sv
// Reset clear walk: steps a pointer over every entry writing zero, then idles.
// Ports: clk, reset (sync, active-high); busy, clr_we, clr_addr to the array.
module integer_file_mp_clear_seq
    import integer_file_mp_pkg::*;
#(
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_e     state_q;
    rf_state_e     state_d;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                // ptr wraps to 0 here, but the state change makes it moot
                if (ptr_q == AW'(DEPTH - 1))
                    state_d = READY;
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign clr_addr = ptr_q;

endmodule

// File: rtl/integer_file_mp.sv
// Multi-port integer register file with write-to-read bypass and clear walk.
// Ports: CLK, RESET; RS_ADDR/RS read ports; RD_ADDR/WR_EN/RD write ports; BUSY.
module integer_file_mp
    import integer_file_mp_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 32,
    parameter int NUM_RD       = 2,
    parameter int NUM_WR       = 1,
    parameter int ZERO_REG     = 1,
    parameter int READ_LATENCY = 0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NUM_RD*AW-1:0]    RS_ADDR,
    output logic [NUM_RD*WIDTH-1:0] RS,
    input  logic [NUM_WR*AW-1:0]    RD_ADDR,
    input  logic [NUM_WR-1:0]       WR_EN,
    input  logic [NUM_WR*WIDTH-1:0] RD,
    output logic                    BUSY
);

    if (NUM_RD < 1 || NUM_RD > RF_MAX_RD) begin : g_bad_rd
        $error("NUM_RD out of range");
    end
    if (NUM_WR < 1 || NUM_WR > RF_MAX_WR) begin : g_bad_wr
        $error("NUM_WR out of range");
    end

    logic                    busy;
    logic                    clr_we;
    logic [AW-1:0]           clr_addr;
    logic [WIDTH-1:0]        mem [DEPTH];
    logic [NUM_RD*WIDTH-1:0] rs_comb;

    integer_file_mp_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk      (CLK),
        .reset    (RESET),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign BUSY = busy;

    // No per-entry reset so the array can map onto RAM.
    // Later ports overwrite earlier ones, so the highest index wins.
    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (!RESET) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (WR_EN[j] &&
                    !(ZERO_REG != 0 && RD_ADDR[j*AW +: AW] == '0))
                    mem[RD_ADDR[j*AW +: AW]] <= RD[j*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] val;

        always_comb begin
            addr = RS_ADDR[k*AW +: AW];
            val  = mem[addr];
            for (int j = 0; j < NUM_WR; j++) begin
                if (WR_EN[j] && RD_ADDR[j*AW +: AW] == addr)
                    val = RD[j*WIDTH +: WIDTH];
            end
            if (busy || (ZERO_REG != 0 && addr == '0))
                val = '0;
        end

        assign rs_comb[k*WIDTH +: WIDTH] = val;
    end

    if (READ_LATENCY == RF_READ_REG) begin : g_reg
        logic [NUM_RD*WIDTH-1:0] rs_q;

        always_ff @(posedge CLK) begin
            if (RESET || busy)
                rs_q <= '0;
            else
                rs_q <= rs_comb;
        end

        assign RS = rs_q;
    end else begin : g_comb
        assign RS = rs_comb;
    end

endmodule

// File: tb/tb_integer_file_mp.sv
// Scoreboard bench: a combinational zero-reg instance and a registered
// no-zero-reg instance share stimulus and are checked against a golden model.
module tb_integer_file_mp;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NR = 4;
    localparam int NW = 2;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [NR*AW-1:0] rs_addr;
    logic [NR*W-1:0]  rs_a;
    logic [NR*W-1:0]  rs_b;
    logic [NW*AW-1:0] rd_addr;
    logic [NW-1:0]    wr_en;
    logic [NW*W-1:0]  rd;
    logic             busy_a;
    logic             busy_b;

    integer_file_mp #(
        .WIDTH(W), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW),
        .ZERO_REG(1), .READ_LATENCY(0)
    ) dut_a (
        .CLK(clk), .RESET(reset), .RS_ADDR(rs_addr), .RS(rs_a),
        .RD_ADDR(rd_addr), .WR_EN(wr_en), .RD(rd), .BUSY(busy_a)
    );

    integer_file_mp #(
        .WIDTH(W), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW),
        .ZERO_REG(0), .READ_LATENCY(1)
    ) dut_b (
        .CLK(clk), .RESET(reset), .RS_ADDR(rs_addr), .RS(rs_b),
        .RD_ADDR(rd_addr), .WR_EN(wr_en), .RD(rd), .BUSY(busy_b)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]    mem_a [D];
    logic [W-1:0]    mem_b [D];
    int              cnt;
    logic [NR*W-1:0] q_b [$];
    logic [NR*W-1:0] obs_a;
    logic [NR*W-1:0] obs_b;
    logic            obs_busy;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_rd(input bit zr,
                                              input logic [AW-1:0] a);
        logic [W-1:0] v;
        if (cnt > 0) return '0;
        v = zr ? mem_a[a] : mem_b[a];
        for (int j = 0; j < NW; j++)
            if (wr_en[j] && rd_addr[j*AW +: AW] == a)
                v = rd[j*W +: W];
        if (zr && a == '0) v = '0;
        return v;
    endfunction

    task automatic step(input logic r, input logic [NR*AW-1:0] ra,
                        input logic [NW*AW-1:0] wa, input logic [NW-1:0] we,
                        input logic [NW*W-1:0] wd);
        logic [NR*W-1:0] ea;
        logic [NR*W-1:0] eb;
        logic [AW-1:0]   a;
        #1;
        reset = r; rs_addr = ra; rd_addr = wa; wr_en = we; rd = wd;
        for (int k = 0; k < NR; k++) begin
            ea[k*W +: W] = model_rd(1'b1, ra[k*AW +: AW]);
            eb[k*W +: W] = model_rd(1'b0, ra[k*AW +: AW]);
        end
        q_b.push_back(r ? '0 : eb);
        @(negedge clk);
        obs_a = rs_a; obs_b = rs_b; obs_busy = busy_a;
        chk("busy_a", 128'(busy_a), 128'(cnt > 0));
        chk("busy_b", 128'(busy_b), 128'(cnt > 0));
        for (int k = 0; k < NR; k++)
            chk($sformatf("rs_a%0d", k), 128'(rs_a[k*W +: W]),
                128'(ea[k*W +: W]));
        if (q_b.size() > 1) begin
            eb = q_b.pop_front();
            for (int k = 0; k < NR; k++)
                chk($sformatf("rs_b%0d", k), 128'(rs_b[k*W +: W]),
                    128'(eb[k*W +: W]));
        end
        @(posedge clk);
        if (r) begin
            cnt = D;
            for (int i = 0; i < D; i++) begin
                mem_a[i] = '0; mem_b[i] = '0;
            end
        end else if (cnt > 0) begin
            cnt--;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (we[j]) begin
                    a = wa[j*AW +: AW];
                    if (a != '0) mem_a[a] = wd[j*W +: W];
                    mem_b[a] = wd[j*W +: W];
                end
            end
        end
    endtask

    task automatic idle(input logic [NR*AW-1:0] ra);
        step(1'b0, ra, '0, '0, '0);
    endtask

    initial begin
        int n;
        reset = 1'b1; rs_addr = '0; rd_addr = '0; wr_en = '0; rd = '0;
        cnt = D;
        for (int i = 0; i < D; i++) begin
            mem_a[i] = '0; mem_b[i] = '0;
        end
        repeat (2) @(posedge clk);

        // reset walk length and cleared contents
        step(1'b1, '0, '0, '0, '0);
        n = 0;
        for (int i = 0; i < D; i++) begin
            idle(20'(i));
            n += int'(obs_busy);
        end
        chk("busy_len", 128'(n), 128'(32));
        idle('0);
        chk("busy_end", 128'(obs_busy), 128'(0));
        for (int i = 0; i < D / 4; i++) begin
            idle({5'(4*i+3), 5'(4*i+2), 5'(4*i+1), 5'(4*i)});
            chk("walk_zero_a", 128'(obs_a), 128'(0));
        end

        // reset mid-walk, write during busy dropped
        step(1'b1, '0, '0, '0, '0);
        repeat (10) idle('0);
        step(1'b1, '0, '0, '0, '0);
        n = 0;
        for (int i = 0; i < D; i++) begin
            step(1'b0, 20'd5, {5'd0, 5'd5}, 2'b01, {32'd0, 32'h55555555});
            n += int'(obs_busy);
        end
        chk("busy_len2", 128'(n), 128'(32));
        idle(20'd5);
        chk("busy_end2", 128'(obs_busy), 128'(0));
        chk("x5_dropped", 128'(obs_a[31:0]), 128'(0));

        // dual write to same address, port 1 wins
        step(1'b0, 20'd7, {5'd7, 5'd7}, 2'b11,
             {32'h22222222, 32'h11111111});
        chk("x7_bypass", 128'(obs_a[31:0]), 128'h22222222);
        idle(20'd7);
        chk("x7_stored", 128'(obs_a[31:0]), 128'h22222222);
        chk("x7_byp_reg", 128'(obs_b[31:0]), 128'h22222222);

        // zero register
        step(1'b0, 20'd0, {5'd0, 5'd0}, 2'b01, {32'd0, 32'hDEADBEEF});
        chk("x0_zero", 128'(obs_a[31:0]), 128'(0));
        idle(20'd0);
        chk("x0_zero_later", 128'(obs_a[31:0]), 128'(0));
        chk("x0_byp_nz", 128'(obs_b[31:0]), 128'hDEADBEEF);
        idle(20'd0);
        chk("x0_stored_nz", 128'(obs_b[31:0]), 128'hDEADBEEF);

        // registered read latency
        step(1'b0, '0, {5'd0, 5'd4}, 2'b01, {32'd0, 32'h44444444});
        step(1'b0, 20'd3, {5'd0, 5'd3}, 2'b01, {32'd0, 32'hA5A5A5A5});
        idle(20'd4);
        chk("x3_reg", 128'(obs_b[31:0]), 128'hA5A5A5A5);
        idle(20'd4);
        chk("x4_reg", 128'(obs_b[31:0]), 128'h44444444);

        // random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 999) == 0, 20'($urandom),
                 10'($urandom), 2'($urandom), {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
